// File: rtl/alarm_clock_multi.sv
// alarm_clock_multi: 24-hour clock with a bank of programmable alarms.
// A prescaler turns TICKS_PER_SEC clk cycles into one tick; each tick
// advances hh:mm:ss, and a slot whose hh:mm equals the new time at ss=0
// latches the alarm output until it is acknowledged.
// Optional snooze support is built when ALARM_CLOCK_SNOOZE_EN is defined.
module alarm_clock_multi #(
    parameter int TICKS_PER_SEC = 1,
    parameter int NUM_ALARMS    = 4,
    parameter int SNOOZE_MIN    = 5
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  ena,
    input  logic                                                  set_time,
    input  logic [4:0]                                            set_hours,
    input  logic [5:0]                                            set_minutes,
    input  logic                                                  alarm_wr,
    input  logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] alarm_idx,
    input  logic [4:0]                                            alarm_hours,
    input  logic [5:0]                                            alarm_minutes,
    input  logic                                                  alarm_en,
    input  logic                                                  alarm_ack,
    input  logic                                                  snooze,
    output logic [4:0]                                            hours,
    output logic [5:0]                                            minutes,
    output logic [5:0]                                            seconds,
    output logic                                                  sec_pulse,
    output logic                                                  alarm,
    output logic [2:0]                                            alarm_id
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [PRE_W-1:0] r_presc;
    logic [4:0]       r_hours;
    logic [5:0]       r_minutes;
    logic [5:0]       r_seconds;
    logic             r_sec_pulse;
    logic             r_alarm;
    logic [2:0]       r_alarm_id;

    logic             r_al_en [NUM_ALARMS];
    logic [4:0]       r_al_h  [NUM_ALARMS];
    logic [5:0]       r_al_m  [NUM_ALARMS];

    logic             w_tick;
    logic             w_set_ok;
    logic             w_adv;
    logic             w_wr_ok;
    logic [4:0]       w_nhour;
    logic [5:0]       w_nmin;
    logic [5:0]       w_nsec;
    logic             w_hit;
    logic [2:0]       w_hit_id;

    assign w_tick   = ena && (r_presc == PRE_W'(TICKS_PER_SEC - 1));
    assign w_set_ok = set_time && (set_hours <= 5'd23) && (set_minutes <= 6'd59);
    // A valid time load pre-empts the tick, so nothing advances that cycle.
    assign w_adv    = w_tick && !w_set_ok;
    assign w_wr_ok  = alarm_wr && (int'(alarm_idx) < NUM_ALARMS)
                      && (alarm_hours <= 5'd23) && (alarm_minutes <= 6'd59);

    // Time one second ahead of the current registers, with carries.
    always_comb begin
        w_nsec  = r_seconds;
        w_nmin  = r_minutes;
        w_nhour = r_hours;
        if (r_seconds == 6'd59) begin
            w_nsec = 6'd0;
            if (r_minutes == 6'd59) begin
                w_nmin  = 6'd0;
                w_nhour = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
            end else begin
                w_nmin = r_minutes + 6'd1;
            end
        end else begin
            w_nsec = r_seconds + 6'd1;
        end
    end

    // Lowest-index enabled slot matching the post-increment time at ss=0.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_id = 3'd0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (r_al_en[i] && (r_al_h[i] == w_nhour) && (r_al_m[i] == w_nmin)) begin
                w_hit    = 1'b1;
                w_hit_id = 3'(i);
            end
        end
        w_hit = w_hit && w_adv && (w_nsec == 6'd0);
    end

    // Prescaler, timekeeping and the one-cycle second pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_hours     <= 5'd0;
            r_minutes   <= 6'd0;
            r_seconds   <= 6'd0;
            r_sec_pulse <= 1'b0;
        end else begin
            r_sec_pulse <= w_adv;
            if (w_set_ok) begin
                r_presc   <= '0;
                r_hours   <= set_hours;
                r_minutes <= set_minutes;
                r_seconds <= 6'd0;
            end else if (w_tick) begin
                r_presc   <= '0;
                r_hours   <= w_nhour;
                r_minutes <= w_nmin;
                r_seconds <= w_nsec;
            end else if (ena) begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    // Alarm slot bank; malformed writes leave the slot untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_al_en[i] <= 1'b0;
                r_al_h[i]  <= 5'd0;
                r_al_m[i]  <= 6'd0;
            end
        end else if (w_wr_ok) begin
            r_al_en[alarm_idx] <= alarm_en;
            r_al_h[alarm_idx]  <= alarm_hours;
            r_al_m[alarm_idx]  <= alarm_minutes;
        end
    end

`ifdef ALARM_CLOCK_SNOOZE_EN
    logic       r_snz_arm;
    logic [4:0] r_snz_h;
    logic [5:0] r_snz_m;
    logic [2:0] r_snz_id;
    logic [6:0] w_snz_msum;
    logic [4:0] w_snz_th;
    logic [5:0] w_snz_tm;
    logic       w_snz_hit;

    // Snooze target = current hh:mm + SNOOZE_MIN, wrapping at 24 h.
    always_comb begin
        w_snz_msum = {1'b0, r_minutes} + 7'(SNOOZE_MIN);
        w_snz_th   = r_hours;
        w_snz_tm   = w_snz_msum[5:0];
        if (w_snz_msum >= 7'd60) begin
            w_snz_tm = 6'(w_snz_msum - 7'd60);
            w_snz_th = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
        end
    end

    assign w_snz_hit = r_snz_arm && w_adv && (w_nsec == 6'd0)
                       && (w_nhour == r_snz_h) && (w_nmin == r_snz_m);

    // Latched alarm with slot > snooze > ack > snooze-request priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alarm    <= 1'b0;
            r_alarm_id <= 3'd0;
            r_snz_arm  <= 1'b0;
            r_snz_h    <= 5'd0;
            r_snz_m    <= 6'd0;
            r_snz_id   <= 3'd0;
        end else begin
            if (w_hit) begin
                r_alarm    <= 1'b1;
                r_alarm_id <= w_hit_id;
            end else if (w_snz_hit) begin
                r_alarm    <= 1'b1;
                r_alarm_id <= r_snz_id;
            end else if (alarm_ack) begin
                r_alarm <= 1'b0;
            end else if (snooze && r_alarm) begin
                r_alarm <= 1'b0;
            end
            if (alarm_ack) begin
                r_snz_arm <= 1'b0;
            end else if (snooze && r_alarm && !w_hit && !w_snz_hit) begin
                r_snz_arm <= 1'b1;
                r_snz_h   <= w_snz_th;
                r_snz_m   <= w_snz_tm;
                r_snz_id  <= r_alarm_id;
            end else if (w_snz_hit) begin
                r_snz_arm <= 1'b0;
            end
        end
    end
`else
    logic w_unused_snooze;
    assign w_unused_snooze = snooze;

    // Latched alarm; a match in the same cycle as an ack keeps it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alarm    <= 1'b0;
            r_alarm_id <= 3'd0;
        end else if (w_hit) begin
            r_alarm    <= 1'b1;
            r_alarm_id <= w_hit_id;
        end else if (alarm_ack) begin
            r_alarm <= 1'b0;
        end
    end
`endif

    assign hours     = r_hours;
    assign minutes   = r_minutes;
    assign seconds   = r_seconds;
    assign sec_pulse = r_sec_pulse;
    assign alarm     = r_alarm;
    assign alarm_id  = r_alarm_id;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Bench for alarm_clock_multi (default build, snooze disabled).
// Each driven cycle is fed to a seconds-of-day reference model whose
// predicted outputs go into exp_q; a monitor pops one entry per clock
// edge and compares it with the DUT.
module tb_alarm_clock_multi;
    localparam int TPS = 4;
    localparam int N   = 4;
    localparam int DAY = 86400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       set_time = 1'b0;
    logic [4:0] set_hours = 5'd0;
    logic [5:0] set_minutes = 6'd0;
    logic       alarm_wr = 1'b0;
    logic [1:0] alarm_idx = 2'd0;
    logic [4:0] alarm_hours = 5'd0;
    logic [5:0] alarm_minutes = 6'd0;
    logic       alarm_en = 1'b0;
    logic       alarm_ack = 1'b0;
    logic       snooze = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       sec_pulse;
    logic       alarm;
    logic [2:0] alarm_id;

    alarm_clock_multi #(.TICKS_PER_SEC(TPS), .NUM_ALARMS(N), .SNOOZE_MIN(5)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .set_time(set_time),
        .set_hours(set_hours), .set_minutes(set_minutes),
        .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .snooze(snooze), .hours(hours), .minutes(minutes), .seconds(seconds),
        .sec_pulse(sec_pulse), .alarm(alarm), .alarm_id(alarm_id)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver state ----------------
    int d_rst_n = 0, d_ena = 0, d_set = 0, d_sh = 0, d_sm = 0;
    int d_aw = 0, d_ai = 0, d_ah = 0, d_am = 0, d_ae = 0, d_ack = 0, d_snz = 0;

    // ---------------- reference model ----------------
    int m_t = 0;        // seconds since midnight
    int m_pre = 0;
    int m_alarm = 0;
    int m_id = 0;
    int m_pulse = 0;
    int slot_on [N];
    int slot_mod[N];    // alarm time as minutes since midnight

    logic [21:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int cyc = 0;

    task automatic model_step();
        int  hit;
        bit  set_ok;
        bit  tick;
        m_pulse = 0;
        if (d_rst_n == 0) begin
            m_t = 0; m_pre = 0; m_alarm = 0; m_id = 0;
            for (int i = 0; i < N; i++) begin
                slot_on[i] = 0; slot_mod[i] = 0;
            end
        end else begin
            hit    = -1;
            set_ok = (d_set != 0) && (d_sh < 24) && (d_sm < 60);
            tick   = (d_ena != 0) && (m_pre == TPS - 1);
            if (set_ok) begin
                m_t = d_sh * 3600 + d_sm * 60;
                m_pre = 0;
            end else if (tick) begin
                m_pre = 0;
                m_t = (m_t + 1) % DAY;
                m_pulse = 1;
                if (m_t % 60 == 0)
                    for (int i = 0; i < N; i++)
                        if (hit < 0 && slot_on[i] != 0 && slot_mod[i] == m_t / 60) hit = i;
            end else if (d_ena != 0) begin
                m_pre++;
            end
            if (hit >= 0) begin
                m_alarm = 1; m_id = hit;
            end else if (d_ack != 0) begin
                m_alarm = 0;
            end
            if (d_aw != 0 && d_ai < N && d_ah < 24 && d_am < 60) begin
                slot_on[d_ai]  = d_ae;
                slot_mod[d_ai] = d_ah * 60 + d_am;
            end
        end
        exp_q.push_back({5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60),
                         1'(m_pulse), 1'(m_alarm), 3'(m_id)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_cycle();
        @(negedge clk);
        rst_n = 1'(d_rst_n); ena = 1'(d_ena); set_time = 1'(d_set);
        set_hours = 5'(d_sh); set_minutes = 6'(d_sm);
        alarm_wr = 1'(d_aw); alarm_idx = 2'(d_ai); alarm_hours = 5'(d_ah);
        alarm_minutes = 6'(d_am); alarm_en = 1'(d_ae); alarm_ack = 1'(d_ack);
        snooze = 1'(d_snz);
        model_step();
        d_set = 0; d_aw = 0; d_ack = 0; d_snz = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic load_time(input int h, input int m);
        d_set = 1; d_sh = h; d_sm = m;
        do_cycle();
    endtask

    task automatic wr_slot(input int i, input int h, input int m, input int e);
        d_aw = 1; d_ai = i; d_ah = h; d_am = m; d_ae = e;
        do_cycle();
    endtask

    task automatic ack();
        d_ack = 1;
        do_cycle();
    endtask

    // Run until the next cycle is the tick that lands on target_t.
    task automatic run_to_tick_into(input int target_t);
        int budget = 0;
        while (!(d_ena != 0 && m_pre == TPS - 1 && (m_t + 1) % DAY == target_t)) begin
            do_cycle();
            budget++;
            if (budget > 2000) begin
                errors++; checks++;
                $display("FAIL tick_wait target=%0d not reached within budget", target_t);
                return;
            end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [21:0] exp_w;
        logic [21:0] act_w;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                act_w = {hours, minutes, seconds, sec_pulse, alarm, alarm_id};
                checks++;
                if (sec_pulse === 1'b1) pulse_cnt++;
                if (act_w !== exp_w) begin
                    errors++;
                    $display("FAIL scoreboard cyc=%0d actual %0d:%0d:%0d p=%0b a=%0b id=%0d expected %0d:%0d:%0d p=%0b a=%0b id=%0d",
                             cyc, act_w[21:17], act_w[16:11], act_w[10:5], act_w[4], act_w[3], act_w[2:0],
                             exp_w[21:17], exp_w[16:11], exp_w[10:5], exp_w[4], exp_w[3], exp_w[2:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        // reset
        d_rst_n = 0; d_ena = 1;
        run(3);
        settle();
        chk("reset_alarm", int'(alarm), 0);
        chk("reset_time", int'({hours, minutes, seconds}), 0);
        d_rst_n = 1;
        run(12);

        // wrap 23:59 -> 00:00:00 after 240 cycles, 60 pulses
        load_time(23, 59);
        pulse_cnt = 0;
        run(240);
        settle();
        chk("wrap_time", int'({hours, minutes, seconds}), 0);
        chk("wrap_pulses", pulse_cnt, 60);

        // basic alarm on slot 2
        wr_slot(2, 7, 30, 1);
        load_time(7, 29);
        run(240);
        settle();
        chk("basic_alarm", int'(alarm), 1);
        chk("basic_id", int'(alarm_id), 2);
        run(20);
        settle();
        chk("basic_hold_sec", int'(seconds), 5);
        chk("basic_hold", int'(alarm), 1);
        ack();
        settle();
        chk("basic_ack", int'(alarm), 0);
        chk("basic_ack_id", int'(alarm_id), 2);

        // priority between slots 0 and 3
        wr_slot(0, 6, 0, 1);
        wr_slot(3, 6, 0, 1);
        load_time(5, 59);
        run(240);
        settle();
        chk("prio_id0", int'(alarm_id), 0);
        ack();
        wr_slot(0, 6, 0, 0);
        wr_slot(3, 24, 0, 0);   // out of range, slot 3 stays enabled
        load_time(5, 59);
        run(240);
        settle();
        chk("prio_id3", int'(alarm_id), 3);
        chk("prio_alarm", int'(alarm), 1);
        ack();

        // freeze, invalid load, load onto an alarm time
        d_ena = 0;
        run(10);
        d_ena = 1;
        load_time(12, 60);
        wr_slot(1, 8, 15, 1);
        load_time(8, 15);
        run(8);
        settle();
        chk("set_no_alarm", int'(alarm), 0);

        // ack collides with a new slot match
        wr_slot(1, 9, 0, 1);
        wr_slot(0, 9, 1, 1);
        load_time(8, 59);
        run(240);
        run_to_tick_into(9 * 3600 + 60);
        ack();
        settle();
        chk("collide_alarm", int'(alarm), 1);
        chk("collide_id", int'(alarm_id), 0);
        ack();

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            d_ena = ($urandom_range(0, 9) != 0) ? 1 : 0;
            d_snz = $urandom_range(0, 1);
            if ($urandom_range(0, 199) == 0) begin
                d_set = 1; d_sh = $urandom_range(0, 25); d_sm = $urandom_range(0, 63);
            end
            if ($urandom_range(0, 39) == 0) begin
                d_aw = 1; d_ai = $urandom_range(0, N - 1);
                d_ah = ($urandom_range(0, 7) == 0) ? 24 : m_t / 3600;
                d_am = ($urandom_range(0, 7) == 0) ? 60 + $urandom_range(0, 3)
                                                   : ((m_t / 60) % 60 + $urandom_range(0, 2)) % 60;
                d_ae = ($urandom_range(0, 3) != 0) ? 1 : 0;
            end
            if ($urandom_range(0, 49) == 0) d_ack = 1;
            d_rst_n = ($urandom_range(0, 999) == 0) ? 0 : 1;
            do_cycle();
        end
        d_rst_n = 1;
        run(2);

        // drain the scoreboard with a bounded wait
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain actual=%0d pending expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alarm_clock_multi.md
# alarm_clock_multi

Parametrised multi-alarm 24-hour clock: counts seconds, minutes and hours from a prescaled system clock and compares the time against a bank of independently programmable alarms. An alarm latches until acknowledged, and the clock keeps running while an alarm is active. This block is the next-generation timekeeping core for the TinyTapeout clock/alarm designs and sits directly behind the user I/O mux.

## Interface

Parameters:
- TICKS_PER_SEC, default 1 — clk cycles per second; legal range ≥1.
- NUM_ALARMS, default 4 — number of alarm slots; legal range 1..8.
- SNOOZE_MIN, default 5 — snooze delay in minutes; legal range 1..59.

Ports:
- clk  in  1 — system clock.
- rst_n  in  1 — synchronous, active-low reset.
- ena  in  1 — enables timekeeping; when low, the prescaler and time freeze.
- set_time  in  1 — single-cycle strobe that loads the time.
- set_hours  in  5 — hour value for set_time.
- set_minutes  in  6 — minute value for set_time.
- alarm_wr  in  1 — single-cycle strobe that writes an alarm slot.
- alarm_idx  in  max(1,$clog2(NUM_ALARMS)) — slot index for alarm_wr.
- alarm_hours  in  5 — alarm hour for the slot write.
- alarm_minutes  in  6 — alarm minute for the slot write.
- alarm_en  in  1 — enable bit for the slot write.
- alarm_ack  in  1 — clears an active alarm.
- snooze  in  1 — snooze request (SNOOZE_EN builds only).
- hours  out  5 — current hour, 0..23.
- minutes  out  6 — current minute, 0..59.
- seconds  out  6 — current second, 0..59.
- sec_pulse  out  1 — high for 1 cycle when the time advances.
- alarm  out  1 — alarm active (latched).
- alarm_id  out  3 — slot that caused the active alarm.

## Operation

- Reset (rst_n low at a clk edge):
  - Time is 00:00:00 and the prescaler is 0.
  - All slots are 00:00 and disabled.
  - alarm=0, alarm_id=0, sec_pulse=0, snooze inactive.
- Tick: a cycle in which ena=1 and the prescaler equals TICKS_PER_SEC-1. The prescaler then returns to 0; otherwise it increments while ena=1.
- On a tick, the time advances by one second:
  - 59 s wraps to 0 s and carries into minutes.
  - 59 min wraps to 0 min and carries into hours.
  - 23:59:59 wraps to 00:00:00.
- set_time:
  - Loads set_hours:set_minutes:00 and clears the prescaler.
  - If set_hours>23 or set_minutes>59, the entire write is discarded.
  - set_time has priority over a tick in the same cycle; no sec_pulse is produced in that cycle.
- alarm_wr:
  - Writes {alarm_en, alarm_hours, alarm_minutes} into slot alarm_idx.
  - The write is discarded if the index is ≥NUM_ALARMS or either value is out of range.
  - The write does not affect an already-latched alarm.
- Match:
  - Evaluated only on a tick, against the post-increment time.
  - A slot fires if it is enabled, its hour and minute equal the new hours:minutes, and the new seconds equal 0.
  - Loading a matching time with set_time never fires an alarm.
- On a match, alarm is set to 1 and alarm_id is set to the lowest matching index.
- alarm stays 1 until alarm_ack or snooze.
- If a match occurs while alarm is already 1, alarm_id is overwritten by the new match.
- alarm_ack and a match in the same cycle: the match wins, so alarm stays 1 and alarm_id is updated.
- alarm_ack while alarm=0 has no effect.

## Timing

- The first tick occurs TICKS_PER_SEC cycles after reset is released, provided ena stays high.
- On the edge ending the tick cycle, hours/minutes/seconds, sec_pulse and alarm all update together. Latency from tick to alarm is 0 cycles beyond the time update.
- On the edge ending an alarm_ack cycle, alarm becomes 0 and alarm_id holds its value.
- set_time, alarm_wr, alarm_ack and snooze are sampled every cycle and are independent of ena.
- sec_pulse is a registered pulse exactly 1 cycle wide.

## Configuration

- Macro: ALARM_CLOCK_SNOOZE_EN.
- Defined:
  - snooze=1 while alarm=1 clears alarm on the next edge.
  - It arms a snooze target at the current hours:minutes plus SNOOZE_MIN, wrapping modulo 24 h, and remembers the current alarm_id.
  - When the snooze target matches on a tick (new seconds=0), alarm is set to 1 with the remembered alarm_id. The target is then disarmed.
  - A new snooze re-arms the target, replacing any previous one.
  - alarm_ack disarms any pending snooze target.
  - snooze and alarm_ack in the same cycle: alarm_ack wins.
  - A slot match and a snooze match in the same tick: the slot wins.
- Undefined:
  - The snooze port is ignored and no snooze registers exist.

## Test plan

- Wrap: TICKS_PER_SEC=4; set_time 23:59, run 60 ticks → 00:00:00 after 240 cycles from the load, with sec_pulse high exactly 60 times.
- Basic alarm: slot 2 = 07:30 enabled; set_time 07:29, run 60 ticks → alarm=1 and alarm_id=2 on the edge where the time shows 07:30:00. alarm is still 1 at 07:30:05; alarm_ack → alarm=0.
- Priority: slots 0 and 3 both = 06:00 enabled → alarm_id=0. With slot 0 disabled, the same run → alarm_id=3. Slot written with hours=24 → slot unchanged.
- Freeze/set: ena low for 10 cycles → time and prescaler unchanged. set_time 12:00 with set_minutes=60 → time unchanged. Set to the alarm time 08:15 → no alarm.
- Ack collision: alarm active from slot 1; alarm_ack asserted in the tick where slot 0 matches → alarm stays 1, alarm_id=0.
- Snooze (ALARM_CLOCK_SNOOZE_EN, SNOOZE_MIN=5): alarm at 23:58 from slot 1; snooze → alarm=0, then alarm=1 with alarm_id=1 at 00:03:00. Reset mid-snooze → nothing fires at 00:03.
